// File: rtl/pkt_rr_arbiter.sv
// Two-port packet merger with packet-granular round-robin and a registered output stage.
// Define ARB_PKT_CNT_EN to add per-port packet counters (pkt_cnt0 / pkt_cnt1).
module pkt_rr_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din0,
    input  logic        din0_sop,
    input  logic        din0_eop,
    input  logic        din0_vld,
    output logic        din0_rdy,
    input  logic [7:0]  din1,
    input  logic        din1_sop,
    input  logic        din1_eop,
    input  logic        din1_vld,
    output logic        din1_rdy,
    output logic [7:0]  dout,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic [1:0]  state_dbg
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1
`endif
);

    // Handshake: a beat moves on any port when its vld && rdy are both high at a rising edge.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_sop_q, dout_sop_d;
    logic       dout_eop_q, dout_eop_d;
    logic       dout_vld_q, dout_vld_d;

    logic       load_en;
    logic       req0, req1;
    logic       acc0, acc1;

    always_comb begin
        load_en      = !dout_vld_q || dout_rdy;
        req0         = din0_vld && din0_sop;
        req1         = din1_vld && din1_sop;
        din0_rdy     = 1'b0;
        din1_rdy     = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // Stray mid-packet beats are drained here; a sop waits for its grant.
                din0_rdy = rst_n && !din0_sop;
                din1_rdy = rst_n && !din1_sop;
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = BUSY0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = BUSY1;
                    last_grant_d = 1'b1;
                end
            end
            BUSY0: begin
                din0_rdy = load_en;
                if (din0_vld && load_en && din0_eop) begin
                    state_d = IDLE;
                end
            end
            BUSY1: begin
                din1_rdy = load_en;
                if (din1_vld && load_en && din1_eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign acc0 = (state_q == BUSY0) && din0_vld && din0_rdy;
    assign acc1 = (state_q == BUSY1) && din1_vld && din1_rdy;

    always_comb begin
        dout_d     = dout_q;
        dout_sop_d = dout_sop_q;
        dout_eop_d = dout_eop_q;
        dout_vld_d = dout_vld_q;
        if (acc0) begin
            dout_d     = din0;
            dout_sop_d = din0_sop;
            dout_eop_d = din0_eop;
            dout_vld_d = 1'b1;
        end else if (acc1) begin
            dout_d     = din1;
            dout_sop_d = din1_sop;
            dout_eop_d = din1_eop;
            dout_vld_d = 1'b1;
        end else if (dout_rdy) begin
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            dout_q       <= 8'h00;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dout_q       <= dout_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            dout_vld_q   <= dout_vld_d;
        end
    end

    assign dout      = dout_q;
    assign dout_sop  = dout_sop_q;
    assign dout_eop  = dout_eop_q;
    assign dout_vld  = dout_vld_q;
    assign state_dbg = state_q;

`ifdef ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q + ((acc0 && din0_eop) ? 16'd1 : 16'd0);
        pkt_cnt1_d = pkt_cnt1_q + ((acc1 && din1_eop) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0_q <= 16'd0;
            pkt_cnt1_q <= 16'd0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: cycle-vector table, directed corner sequences and a
// randomized run scored against per-port expected beat queues.
`timescale 1ns/1ps
module tb_pkt_rr_arbiter;

    localparam bit         H       = 1'b1;
    localparam bit         L       = 1'b0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam int         NV      = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din0, din1, dout;
    logic        din0_sop, din0_eop, din0_vld, din0_rdy;
    logic        din1_sop, din1_eop, din1_vld, din1_rdy;
    logic        dout_sop, dout_eop, dout_vld, dout_rdy;
    logic [1:0]  state_dbg;
`ifdef ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    always #5 clk = ~clk;

    pkt_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .din0(din0), .din0_sop(din0_sop), .din0_eop(din0_eop), .din0_vld(din0_vld), .din0_rdy(din0_rdy),
        .din1(din1), .din1_sop(din1_sop), .din1_eop(din1_eop), .din1_vld(din1_vld), .din1_rdy(din1_rdy),
        .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .state_dbg(state_dbg)
`ifdef ARB_PKT_CNT_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    typedef struct {
        bit         rst;
        bit         v0, s0, e0;
        logic [7:0] d0;
        bit         v1, s1, e1;
        logic [7:0] d1;
        bit         xr0, xr1, xv, xs, xe;
        logic [7:0] xd;
    } vec_t;

    vec_t vec[NV];

    int checks = 0;
    int errors = 0;

    // Beats are {sop, eop, data}.
    logic [9:0] src_q0[$], src_q1[$];
    logic [9:0] exp_q0[$], exp_q1[$];
    logic [9:0] out_log[$];
    logic [9:0] exp_seq[$];
    bit         hold0, hold1, ordy;
    bit         stall_prev;
    logic [10:0] snap_prev;
    bit         in_pkt;
    bit         cur_port;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] mk_beat(input logic [7:0] d, input int i, input int len);
        return {(i == 0), (i == len - 1), d};
    endfunction

    task automatic push_pkt(input int port, input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) begin
            if (port == 0) src_q0.push_back(mk_beat(first + 8'(i), i, len));
            else           src_q1.push_back(mk_beat(first + 8'(i), i, len));
        end
    endtask

    task automatic gen_pkt(input int port);
        int len;
        logic [7:0] d;
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
            d = {(port == 1), 7'($urandom)};
            if (port == 0) src_q0.push_back(mk_beat(d, i, len));
            else           src_q1.push_back(mk_beat(d, i, len));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        din0_vld = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0; din0 = 8'h00;
        din1_vld = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0; din1 = 8'h00;
        dout_rdy = 1'b1;
        src_q0.delete(); src_q1.delete();
        exp_q0.delete(); exp_q1.delete();
        out_log.delete();
        stall_prev = 1'b0;
        in_pkt     = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0; ordy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, before the next rising edge.
    task automatic cycle();
        @(negedge clk);
        dout_rdy = ordy;
        if (src_q0.size() > 0 && !hold0) begin
            din0_vld = 1'b1;
            {din0_sop, din0_eop, din0} = src_q0[0];
        end else begin
            din0_vld = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0;
        end
        if (src_q1.size() > 0 && !hold1) begin
            din1_vld = 1'b1;
            {din1_sop, din1_eop, din1} = src_q1[0];
        end else begin
            din1_vld = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0;
        end
        #1;
        if (stall_prev) check("output hold under backpressure", {dout_vld, dout_sop, dout_eop, dout}, snap_prev);
        if (dout_vld && dout_rdy) out_log.push_back({dout_sop, dout_eop, dout});
        stall_prev = dout_vld && !dout_rdy;
        snap_prev  = {dout_vld, dout_sop, dout_eop, dout};
        if (din0_vld && din0_rdy) exp_q0.push_back(src_q0.pop_front());
        if (din1_vld && din1_rdy) exp_q1.push_back(src_q1.pop_front());
    endtask

    // Every output beat must belong to an unbroken packet whose port is tagged in data bit 7.
    task automatic score();
        logic [9:0] b;
        bit k;
        while (out_log.size() > 0) begin
            b = out_log.pop_front();
            k = b[7];
            if (!in_pkt) check("packet starts with sop", b[9], 1);
            else         check("no interleave", k, cur_port);
            if (k == 1'b0) begin
                if (exp_q0.size() == 0) check("port0 beat expected", 0, 1);
                else                    check("port0 beat", b, exp_q0.pop_front());
            end else begin
                if (exp_q1.size() == 0) check("port1 beat expected", 0, 1);
                else                    check("port1 beat", b, exp_q1.pop_front());
            end
            in_pkt   = !b[8];
            cur_port = k;
        end
    endtask

    task automatic compare_log(input string name);
        check({name, " beat count"}, out_log.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < out_log.size(); i++) begin
            check($sformatf("%s beat %0d", name, i), out_log[i], exp_seq[i]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, v0 s0 e0 d0, v1 s1 e1 d1, exp rdy0 rdy1 vld sop eop dout
        vec[0]  = '{L, H,H,L,8'h11, L,L,L,8'h00, L,H, L,L,L,8'h00};
        vec[1]  = '{L, H,H,L,8'h11, L,L,L,8'h00, H,L, L,L,L,8'h00};
        vec[2]  = '{L, H,L,L,8'h22, L,L,L,8'h00, H,L, H,H,L,8'h11};
        vec[3]  = '{L, H,L,H,8'h33, L,L,L,8'h00, H,L, H,L,L,8'h22};
        vec[4]  = '{L, L,L,L,8'h00, L,L,L,8'h00, H,H, H,L,H,8'h33};
        vec[5]  = '{H, L,L,L,8'h00, L,L,L,8'h00, L,L, L,L,L,8'h00};
        vec[6]  = '{L, H,H,L,8'hA1, H,H,L,8'hB1, L,L, L,L,L,8'h00};
        vec[7]  = '{L, H,H,L,8'hA1, H,H,L,8'hB1, H,L, L,L,L,8'h00};
        vec[8]  = '{L, H,L,H,8'hA2, H,H,L,8'hB1, H,L, H,H,L,8'hA1};
        vec[9]  = '{L, H,H,L,8'hA3, H,H,L,8'hB1, L,L, H,L,H,8'hA2};
        vec[10] = '{L, H,H,L,8'hA3, H,H,L,8'hB1, L,H, L,L,L,8'h00};
        vec[11] = '{L, H,H,L,8'hA3, H,L,H,8'hB2, L,H, H,H,L,8'hB1};
        vec[12] = '{L, H,H,L,8'hA3, H,H,L,8'hB3, L,L, H,L,H,8'hB2};
        vec[13] = '{L, H,H,L,8'hA3, H,H,L,8'hB3, H,L, L,L,L,8'h00};
        vec[14] = '{L, H,L,H,8'hA4, H,H,L,8'hB3, H,L, H,H,L,8'hA3};
        vec[15] = '{L, L,L,L,8'h00, H,H,L,8'hB3, H,L, H,L,H,8'hA4};
        vec[16] = '{L, L,L,L,8'h00, H,H,L,8'hB3, L,H, L,L,L,8'h00};
        vec[17] = '{L, L,L,L,8'h00, H,L,H,8'hB4, L,H, H,H,L,8'hB3};
        vec[18] = '{L, L,L,L,8'h00, L,L,L,8'h00, H,H, H,L,H,8'hB4};
        vec[19] = '{L, L,L,L,8'h00, L,L,L,8'h00, H,H, L,L,L,8'h00};

        rst_n = 1'b0;
        din0_vld = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0; din0 = 8'h00;
        din1_vld = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0; din1 = 8'h00;
        dout_rdy = 1'b1;
        hold0 = 1'b0; hold1 = 1'b0; ordy = 1'b1;
        stall_prev = 1'b0; snap_prev = '0; in_pkt = 1'b0; cur_port = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset dout_vld", dout_vld, 0);
        check("reset dout", {dout_sop, dout_eop, dout}, 0);
        check("reset din0_rdy", din0_rdy, 0);
        check("reset din1_rdy", din1_rdy, 0);
        check("reset state", state_dbg, ST_IDLE);

        // Cycle-accurate vectors: single-port latency, then tie alternation after a reset.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n    = !vec[i].rst;
            din0_vld = vec[i].v0; din0_sop = vec[i].s0; din0_eop = vec[i].e0; din0 = vec[i].d0;
            din1_vld = vec[i].v1; din1_sop = vec[i].s1; din1_eop = vec[i].e1; din1 = vec[i].d1;
            dout_rdy = 1'b1;
            #1;
            check($sformatf("vec%0d din0_rdy", i), din0_rdy, vec[i].xr0);
            check($sformatf("vec%0d din1_rdy", i), din1_rdy, vec[i].xr1);
            check($sformatf("vec%0d dout_vld", i), dout_vld, vec[i].xv);
            if (vec[i].xv || vec[i].rst) begin
                check($sformatf("vec%0d dout_sop", i), dout_sop, vec[i].xs);
                check($sformatf("vec%0d dout_eop", i), dout_eop, vec[i].xe);
                check($sformatf("vec%0d dout", i), dout, vec[i].xd);
            end
        end

        // Port 0 raises sop while port 1 is mid-packet.
        do_reset();
        push_pkt(1, 8'hC1, 4);
        cycle();
        cycle();
        push_pkt(0, 8'h41, 2);
        for (int i = 0; i < 10; i++) cycle();
        exp_seq.delete();
        for (int i = 0; i < 4; i++) exp_seq.push_back(mk_beat(8'hC1 + 8'(i), i, 4));
        for (int i = 0; i < 2; i++) exp_seq.push_back(mk_beat(8'h41 + 8'(i), i, 2));
        compare_log("no-preempt");

        // Downstream stalls three cycles mid-packet.
        do_reset();
        push_pkt(0, 8'h61, 5);
        for (int i = 0; i < 3; i++) cycle();
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("stall%0d din0_rdy", i), din0_rdy, 0);
            check($sformatf("stall%0d dout", i), {dout_vld, dout}, {1'b1, 8'h62});
        end
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        exp_seq.delete();
        for (int i = 0; i < 5; i++) exp_seq.push_back(mk_beat(8'h61 + 8'(i), i, 5));
        compare_log("stall");

        // Stray beat in IDLE, then reset in the middle of a packet.
        do_reset();
        src_q0.push_back({1'b0, 1'b0, 8'h5A});
        cycle();
        check("stray din0_rdy", din0_rdy, 1);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check($sformatf("stray dout_vld %0d", i), dout_vld, 0);
        end
        check("stray consumed", src_q0.size(), 0);
        push_pkt(0, 8'h71, 4);
        for (int i = 0; i < 3; i++) cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        din0_vld = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0;
        #1;
        check("midreset dout", {dout_vld, dout_sop, dout_eop, dout}, 0);
        check("midreset rdy", {din0_rdy, din1_rdy}, 0);
        check("midreset state", state_dbg, ST_IDLE);
        out_log.delete(); exp_q0.delete(); stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i < 2) check($sformatf("leftover din0_rdy %0d", i), din0_rdy, 1);
            check($sformatf("leftover dout_vld %0d", i), dout_vld, 0);
        end
        check("leftover consumed", src_q0.size(), 0);
        check("leftover nothing forwarded", out_log.size(), 0);

`ifdef ARB_PKT_CNT_EN
        do_reset();
        push_pkt(0, 8'h01, 1);
        push_pkt(0, 8'h02, 2);
        push_pkt(0, 8'h04, 3);
        push_pkt(1, 8'h81, 2);
        for (int i = 0; i < 60; i++) cycle();
        check("pkt_cnt0", pkt_cnt0, 3);
        check("pkt_cnt1", pkt_cnt1, 1);
`endif

        // Randomized traffic with random gaps and backpressure.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (src_q0.size() == 0 && $urandom_range(0, 2) == 0) gen_pkt(0);
            if (src_q1.size() == 0 && $urandom_range(0, 2) == 0) gen_pkt(1);
            hold0 = ($urandom_range(0, 4) == 0);
            hold1 = ($urandom_range(0, 4) == 0);
            ordy  = ($urandom_range(0, 3) != 0);
            cycle();
            score();
        end
        hold0 = 1'b0; hold1 = 1'b0; ordy = 1'b1;
        for (int c = 0; c < 400 && (src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size()) != 0; c++) begin
            cycle();
            score();
        end
        check("random drain", src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size(), 0);
        check("random ends on packet boundary", in_pkt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
